// File: rtl/dmem_pkg.sv
// dmem_pkg -- shared definitions for the data-memory controller slice.
//   dmem_state_e         : controller FSM encoding (IDLE, REQ, WAIT, DONE)
//   F3_*                 : funct3 access size/sign codes
//   dmem_size_e          : decoded access size
//   DMEM_TIMEOUT_DEFAULT : default bus timeout in cycles (DMEM_TIMEOUT_EN builds)
//   f3_size / size_mask / is_misaligned : size decode, lane mask, alignment check
package dmem_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_REQ  = 2'b01,
      ST_WAIT = 2'b10,
      ST_DONE = 2'b11
   } dmem_state_e;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   typedef enum logic [1:0] {
      SZ_BYTE = 2'b00,
      SZ_HALF = 2'b01,
      SZ_WORD = 2'b10
   } dmem_size_e;

   localparam int DMEM_TIMEOUT_DEFAULT = 255;

   // Unlisted funct3 codes (011, 110, 111) fall back to a full word.
   function automatic dmem_size_e f3_size(input logic [2:0] f3);
      dmem_size_e sz;
      case (f3)
         F3_B, F3_BU: sz = SZ_BYTE;
         F3_H, F3_HU: sz = SZ_HALF;
         F3_W:        sz = SZ_WORD;
         default:     sz = SZ_WORD;
      endcase
      return sz;
   endfunction

   function automatic logic [3:0] size_mask(input dmem_size_e sz, input logic [1:0] lo);
      logic [3:0] m;
      case (sz)
         SZ_BYTE: m = 4'b0001 << lo;
         SZ_HALF: m = 4'b0011 << {lo[1], 1'b0};
         default: m = 4'b1111;
      endcase
      return m;
   endfunction

   function automatic logic is_misaligned(input dmem_size_e sz, input logic [1:0] lo);
      logic mis;
      case (sz)
         SZ_BYTE: mis = 1'b0;
         SZ_HALF: mis = lo[0];
         default: mis = (lo != 2'b00);
      endcase
      return mis;
   endfunction

endpackage

// File: rtl/dmem_lane.sv
// dmem_lane -- combinational byte-lane steering for the data-memory controller.
//   addr_lo_i   : addr[1:0] of the access
//   funct3_i    : access size/sign
//   wdata_i     : store data in the low lanes
//   rdata_raw_i : raw 32-bit word from the bus
//   be_o        : byte enables for the access size/offset
//   wdata_o     : store data replicated across all lanes
//   rdata_o     : selected and sign/zero-extended load data
module dmem_lane
   import dmem_pkg::*;
(
   input  logic [1:0]  addr_lo_i,
   input  logic [2:0]  funct3_i,
   input  logic [31:0] wdata_i,
   input  logic [31:0] rdata_raw_i,
   output logic [3:0]  be_o,
   output logic [31:0] wdata_o,
   output logic [31:0] rdata_o
);

   dmem_size_e  size_s;
   logic [7:0]  byte_s;
   logic [15:0] half_s;
   logic        signed_s;

   assign size_s   = f3_size(funct3_i);
   assign be_o     = size_mask(size_s, addr_lo_i);
   // funct3[2] clear means a signed load (LB/LH).
   assign signed_s = ~funct3_i[2];

   // Replicate store data so every enabled lane carries the right bytes.
   always_comb begin
      case (size_s)
         SZ_BYTE: wdata_o = {4{wdata_i[7:0]}};
         SZ_HALF: wdata_o = {2{wdata_i[15:0]}};
         default: wdata_o = wdata_i;
      endcase
   end

   // Pick the addressed byte and half-word out of the raw read word.
   always_comb begin
      case (addr_lo_i)
         2'b00:   byte_s = rdata_raw_i[7:0];
         2'b01:   byte_s = rdata_raw_i[15:8];
         2'b10:   byte_s = rdata_raw_i[23:16];
         2'b11:   byte_s = rdata_raw_i[31:24];
         default: byte_s = 8'h00;
      endcase
      if (addr_lo_i[1]) begin
         half_s = rdata_raw_i[31:16];
      end else begin
         half_s = rdata_raw_i[15:0];
      end
   end

   // Extend the selected field to 32 bits.
   always_comb begin
      case (size_s)
         SZ_BYTE: rdata_o = signed_s ? {{24{byte_s[7]}}, byte_s} : {24'h000000, byte_s};
         SZ_HALF: rdata_o = signed_s ? {{16{half_s[15]}}, half_s} : {16'h0000, half_s};
         default: rdata_o = rdata_raw_i;
      endcase
   end

endmodule

// File: rtl/dmem_ctrl.sv
// dmem_ctrl -- MEM-stage data-memory controller (IDLE/REQ/WAIT/DONE FSM).
//   Pipeline side : mem_read_i, mem_write_i, addr_i, wdata_i, funct3_i in;
//                   rdata_o (extended load data), stall_o, misaligned_o, bus_err_o out.
//   Bus side      : bus_req_o, bus_we_o, bus_addr_o, bus_wdata_o, bus_be_o out;
//                   bus_gnt_i, bus_rvalid_i, bus_rdata_i in.
//   Optional macro DMEM_TIMEOUT_EN: abort REQ/WAIT after TIMEOUT_CYCLES cycles
//   with a bus_err_o pulse. Without it REQ/WAIT wait indefinitely and
//   bus_err_o is tied low.
module dmem_ctrl
   import dmem_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = DMEM_TIMEOUT_DEFAULT
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        mem_read_i,
   input  logic        mem_write_i,
   input  logic [31:0] addr_i,
   input  logic [31:0] wdata_i,
   input  logic [2:0]  funct3_i,
   output logic        bus_req_o,
   output logic        bus_we_o,
   output logic [31:0] bus_addr_o,
   output logic [31:0] bus_wdata_o,
   output logic [3:0]  bus_be_o,
   input  logic        bus_gnt_i,
   input  logic        bus_rvalid_i,
   input  logic [31:0] bus_rdata_i,
   output logic [31:0] rdata_o,
   output logic        stall_o,
   output logic        misaligned_o,
   output logic        bus_err_o
);

   if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
      $error("TIMEOUT_CYCLES must be at least 1");
   end

   dmem_state_e state_q, state_d;
   logic [31:0] addr_q;
   logic [31:0] wdata_q;
   logic [2:0]  funct3_q;
   logic        we_q;
   logic [31:0] rdata_q, rdata_d;

   logic        access_s;
   logic        misaligned_s;
   logic        latch_s;
   logic        capture_s;
   logic        abort_s;
   logic        timeout_s;
   logic        stall_s;
   logic        mis_s;
   logic        in_req_s;
   logic [3:0]  lane_be_s;
   logic [31:0] lane_wdata_s;
   logic [31:0] lane_rdata_s;

   assign access_s     = mem_read_i | mem_write_i;
   assign misaligned_s = is_misaligned(f3_size(funct3_i), addr_i[1:0]);
   assign in_req_s     = (state_q == ST_REQ);

   dmem_lane u_lane (
      .addr_lo_i   (addr_q[1:0]),
      .funct3_i    (funct3_q),
      .wdata_i     (wdata_q),
      .rdata_raw_i (bus_rdata_i),
      .be_o        (lane_be_s),
      .wdata_o     (lane_wdata_s),
      .rdata_o     (lane_rdata_s)
   );

   // FSM next-state, stall and capture decisions.
   always_comb begin
      state_d   = state_q;
      stall_s   = 1'b0;
      mis_s     = 1'b0;
      latch_s   = 1'b0;
      capture_s = 1'b0;
      abort_s   = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (access_s) begin
               if (misaligned_s) begin
                  mis_s = 1'b1;
               end else begin
                  latch_s = 1'b1;
                  stall_s = 1'b1;
                  state_d = ST_REQ;
               end
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_REQ: begin
            stall_s = 1'b1;
            if (bus_gnt_i) begin
               if (we_q) begin
                  state_d = ST_DONE;
               end else if (bus_rvalid_i) begin
                  // Zero-wait read: data arrives with the grant.
                  capture_s = 1'b1;
                  state_d   = ST_DONE;
               end else begin
                  state_d = ST_WAIT;
               end
            end else if (timeout_s) begin
               abort_s = 1'b1;
               state_d = ST_DONE;
            end else begin
               state_d = ST_REQ;
            end
         end
         ST_WAIT: begin
            stall_s = 1'b1;
            if (bus_rvalid_i) begin
               capture_s = 1'b1;
               state_d   = ST_DONE;
            end else if (timeout_s) begin
               abort_s = 1'b1;
               state_d = ST_DONE;
            end else begin
               state_d = ST_WAIT;
            end
         end
         ST_DONE: begin
            // The instruction advances this cycle, so its still-present request is ignored.
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // Load result: new data on capture, cleared on an aborted load, otherwise held.
   always_comb begin
      if (capture_s) begin
         rdata_d = lane_rdata_s;
      end else if (abort_s && !we_q) begin
         rdata_d = 32'h0000_0000;
      end else begin
         rdata_d = rdata_q;
      end
   end

   // State, latched access and load-data registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= ST_IDLE;
         addr_q   <= 32'h0000_0000;
         wdata_q  <= 32'h0000_0000;
         funct3_q <= 3'b000;
         we_q     <= 1'b0;
         rdata_q  <= 32'h0000_0000;
      end else begin
         state_q <= state_d;
         rdata_q <= rdata_d;
         if (latch_s) begin
            addr_q   <= addr_i;
            wdata_q  <= wdata_i;
            funct3_q <= funct3_i;
            // A simultaneous read and write is handled as a store.
            we_q     <= mem_write_i;
         end
      end
   end

`ifdef DMEM_TIMEOUT_EN
   localparam logic [31:0] TIMEOUT_LAST = 32'(TIMEOUT_CYCLES - 1);

   logic [31:0] cnt_q, cnt_d;
   logic        bus_err_q;

   // Counter restarts when a new access enters REQ and counts every REQ/WAIT cycle.
   always_comb begin
      if (latch_s) begin
         cnt_d = 32'h0000_0000;
      end else if ((state_q == ST_REQ) || (state_q == ST_WAIT)) begin
         cnt_d = cnt_q + 32'h0000_0001;
      end else begin
         cnt_d = 32'h0000_0000;
      end
   end

   assign timeout_s = (cnt_q == TIMEOUT_LAST);

   // Timeout counter and the one-cycle error pulse shown during DONE.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q     <= 32'h0000_0000;
         bus_err_q <= 1'b0;
      end else begin
         cnt_q     <= cnt_d;
         bus_err_q <= abort_s;
      end
   end

   assign bus_err_o = bus_err_q;
`else
   assign timeout_s = 1'b0;
   assign bus_err_o = 1'b0;
`endif

   // Bus signals are driven from the latched access only while requesting.
   assign bus_req_o    = in_req_s;
   assign bus_we_o     = in_req_s & we_q;
   assign bus_addr_o   = in_req_s ? {addr_q[31:2], 2'b00} : 32'h0000_0000;
   assign bus_be_o     = in_req_s ? lane_be_s : 4'b0000;
   assign bus_wdata_o  = (in_req_s && we_q) ? lane_wdata_s : 32'h0000_0000;
   assign rdata_o      = rdata_q;
   assign stall_o      = stall_s;
   assign misaligned_o = mis_s;

endmodule

// File: tb/tb_dmem_ctrl.sv
// tb_dmem_ctrl -- scoreboard bench for dmem_ctrl. Stimulus pushes expected bus
// transfers, completions, misaligned pulses, resets and bus errors into queues;
// a negedge monitor pops and compares whenever the DUT shows the event.
module tb_dmem_ctrl;

   typedef struct {
      logic [31:0] addr;
      logic [3:0]  be;
      logic [31:0] wdata;
      logic        we;
   } bus_exp_t;

   typedef struct {
      logic [31:0] rdata;
      int          stall;
   } done_exp_t;

   logic        clk;
   logic        rst_n;
   logic        mem_read_i, mem_write_i;
   logic [31:0] addr_i, wdata_i;
   logic [2:0]  funct3_i;
   logic        bus_req_o, bus_we_o;
   logic [31:0] bus_addr_o, bus_wdata_o;
   logic [3:0]  bus_be_o;
   logic        bus_gnt_i, bus_rvalid_i;
   logic [31:0] bus_rdata_i;
   logic [31:0] rdata_o;
   logic        stall_o, misaligned_o, bus_err_o;

   bus_exp_t  bus_q[$];
   done_exp_t done_q[$];
   int        mis_q[$];
   int        rst_q[$];
   int        err_q[$];

   int n_chk  = 0;
   int n_fail = 0;
   int stall_cnt = 0;
   bit in_rst = 1'b0;

   dmem_ctrl #(.TIMEOUT_CYCLES(8)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .mem_read_i   (mem_read_i),
      .mem_write_i  (mem_write_i),
      .addr_i       (addr_i),
      .wdata_i      (wdata_i),
      .funct3_i     (funct3_i),
      .bus_req_o    (bus_req_o),
      .bus_we_o     (bus_we_o),
      .bus_addr_o   (bus_addr_o),
      .bus_wdata_o  (bus_wdata_o),
      .bus_be_o     (bus_be_o),
      .bus_gnt_i    (bus_gnt_i),
      .bus_rvalid_i (bus_rvalid_i),
      .bus_rdata_i  (bus_rdata_i),
      .rdata_o      (rdata_o),
      .stall_o      (stall_o),
      .misaligned_o (misaligned_o),
      .bus_err_o    (bus_err_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   // Monitor: compare DUT events against the queued expectations.
   always @(negedge clk) begin
      if (!rst_n) begin
         if (!in_rst) begin
            in_rst = 1'b1;
            if (rst_q.size() == 0) begin
               chk("reset_unexpected", {31'd0, rst_n}, 32'd1);
            end else begin
               void'(rst_q.pop_front());
               chk("rst_bus_req", {31'd0, bus_req_o}, 32'd0);
               chk("rst_bus_we", {31'd0, bus_we_o}, 32'd0);
               chk("rst_bus_addr", bus_addr_o, 32'd0);
               chk("rst_bus_be", {28'd0, bus_be_o}, 32'd0);
               chk("rst_bus_wdata", bus_wdata_o, 32'd0);
               chk("rst_stall", {31'd0, stall_o}, 32'd0);
               chk("rst_misaligned", {31'd0, misaligned_o}, 32'd0);
               chk("rst_bus_err", {31'd0, bus_err_o}, 32'd0);
               chk("rst_rdata", rdata_o, 32'd0);
            end
         end
         stall_cnt = 0;
      end else begin
         in_rst = 1'b0;
         if (bus_req_o && bus_gnt_i) begin
            if (bus_q.size() == 0) begin
               chk("bus_unexpected", {31'd0, bus_req_o}, 32'd0);
            end else begin
               bus_exp_t b;
               b = bus_q.pop_front();
               chk("bus_addr", bus_addr_o, b.addr);
               chk("bus_be", {28'd0, bus_be_o}, {28'd0, b.be});
               chk("bus_wdata", bus_wdata_o, b.wdata);
               chk("bus_we", {31'd0, bus_we_o}, {31'd0, b.we});
            end
         end
         if (misaligned_o) begin
            if (mis_q.size() == 0) begin
               chk("misaligned_unexpected", {31'd0, misaligned_o}, 32'd0);
            end else begin
               void'(mis_q.pop_front());
               chk("mis_bus_req", {31'd0, bus_req_o}, 32'd0);
               chk("mis_stall", {31'd0, stall_o}, 32'd0);
            end
         end
         if (bus_err_o) begin
            if (err_q.size() == 0) begin
               chk("bus_err_unexpected", {31'd0, bus_err_o}, 32'd0);
            end else begin
               void'(err_q.pop_front());
               chk("err_stall", {31'd0, stall_o}, 32'd0);
               chk("err_rdata", rdata_o, 32'd0);
            end
         end
         if (stall_o) begin
            stall_cnt++;
         end else if (stall_cnt > 0) begin
            if (done_q.size() == 0) begin
               chk("done_unexpected", 32'(stall_cnt), 32'd0);
            end else begin
               done_exp_t d;
               d = done_q.pop_front();
               chk("done_rdata", rdata_o, d.rdata);
               chk("done_stall_cycles", 32'(stall_cnt), 32'(d.stall));
            end
            stall_cnt = 0;
         end
      end
   end

   // Aligned access: gnt after gd idle REQ cycles; read data rvd cycles after gnt.
   task automatic access(input logic rd, input logic wr, input logic [31:0] a,
                         input logic [31:0] wd, input logic [2:0] f3,
                         input int gd, input int rvd, input logic [31:0] word,
                         input logic [3:0] ebe, input logic [31:0] ewd,
                         input logic [31:0] erd);
      bus_exp_t  b;
      done_exp_t d;
      logic      st;
      st      = wr;
      b.addr  = {a[31:2], 2'b00};
      b.be    = ebe;
      b.wdata = st ? ewd : 32'd0;
      b.we    = st;
      d.rdata = erd;
      d.stall = 2 + gd + (st ? 0 : rvd);
      bus_q.push_back(b);
      done_q.push_back(d);
      mem_read_i = rd; mem_write_i = wr; addr_i = a; wdata_i = wd; funct3_i = f3;
      @(posedge clk); #1;
      repeat (gd) begin @(posedge clk); #1; end
      bus_gnt_i = 1'b1;
      if (!st && rvd == 0) begin
         bus_rvalid_i = 1'b1; bus_rdata_i = word;
      end
      @(posedge clk); #1;
      bus_gnt_i = 1'b0; bus_rvalid_i = 1'b0; bus_rdata_i = 32'h0BAD_F00D;
      if (!st && rvd > 0) begin
         repeat (rvd - 1) begin @(posedge clk); #1; end
         bus_rvalid_i = 1'b1; bus_rdata_i = word;
         @(posedge clk); #1;
         bus_rvalid_i = 1'b0; bus_rdata_i = 32'h0BAD_F00D;
      end
      // DONE: the instruction is still presented and must be ignored.
      @(posedge clk); #1;
      mem_read_i = 1'b0; mem_write_i = 1'b0;
   endtask

   task automatic misaligned(input logic rd, input logic wr, input logic [31:0] a, input logic [2:0] f3);
      mis_q.push_back(1);
      mem_read_i = rd; mem_write_i = wr; addr_i = a; funct3_i = f3; wdata_i = 32'h5555_AAAA;
      @(posedge clk); #1;
      mem_read_i = 1'b0; mem_write_i = 1'b0;
      @(posedge clk); #1;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: time limit reached, got running expected finished");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n = 1'b0;
      mem_read_i = 1'b0; mem_write_i = 1'b0; addr_i = 32'd0; wdata_i = 32'd0; funct3_i = 3'b000;
      bus_gnt_i = 1'b0; bus_rvalid_i = 1'b0; bus_rdata_i = 32'd0;
      rst_q.push_back(1);
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      @(posedge clk); #1;

      //        rd    wr    addr          wdata         f3      gd rvd word          be       exp wdata     exp rdata
      access(1'b1, 1'b0, 32'h0000_0103, 32'h0,        3'b000, 0, 0, 32'h80FF_0000, 4'b1000, 32'h0,        32'hFFFF_FF80);
      access(1'b0, 1'b1, 32'h0000_0202, 32'h0000_BEEF, 3'b001, 3, 0, 32'h0,        4'b1100, 32'hBEEF_BEEF, 32'hFFFF_FF80);
      misaligned(1'b1, 1'b0, 32'h0000_0101, 3'b010);
      access(1'b1, 1'b0, 32'h0000_0002, 32'h0,        3'b101, 1, 4, 32'h1234_5678, 4'b1100, 32'h0,        32'h0000_1234);
      access(1'b0, 1'b1, 32'h0000_0001, 32'h1234_56A5, 3'b000, 0, 0, 32'h0,        4'b0010, 32'hA5A5_A5A5, 32'h0000_1234);
      access(1'b0, 1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 3'b010, 1, 0, 32'h0,        4'b1111, 32'hDEAD_BEEF, 32'h0000_1234);
      access(1'b1, 1'b0, 32'h0000_0006, 32'h0,        3'b001, 0, 1, 32'h8001_7FFE, 4'b1100, 32'h0,        32'hFFFF_8001);
      access(1'b1, 1'b0, 32'h0000_0102, 32'h0,        3'b100, 2, 0, 32'h00C3_0000, 4'b0100, 32'h0,        32'h0000_00C3);
      access(1'b1, 1'b0, 32'h0000_0020, 32'h0,        3'b011, 0, 2, 32'hCAFE_F00D, 4'b1111, 32'h0,        32'hCAFE_F00D);
      access(1'b1, 1'b1, 32'h0000_0030, 32'h1122_3344, 3'b010, 0, 0, 32'h0,        4'b1111, 32'h1122_3344, 32'hCAFE_F00D);
      access(1'b1, 1'b0, 32'h0000_0028, 32'h0,        3'b111, 0, 0, 32'h8765_4321, 4'b1111, 32'h0,        32'h8765_4321);
      misaligned(1'b0, 1'b1, 32'h0000_0003, 3'b001);
      misaligned(1'b1, 1'b0, 32'h0000_0005, 3'b101);

      // Reset asserted while the load sits in WAIT.
      begin
         bus_exp_t b;
         b.addr = 32'h0000_0040; b.be = 4'b1111; b.wdata = 32'd0; b.we = 1'b0;
         bus_q.push_back(b);
         mem_read_i = 1'b1; addr_i = 32'h0000_0040; funct3_i = 3'b010;
         @(posedge clk); #1;
         bus_gnt_i = 1'b1;
         @(posedge clk); #1;
         bus_gnt_i = 1'b0;
         @(posedge clk); #1;
         mem_read_i = 1'b0;
         rst_q.push_back(1);
         rst_n = 1'b0;
         @(posedge clk); #1;
         rst_n = 1'b1;
         @(posedge clk); #1;
      end
      access(1'b1, 1'b0, 32'h0000_0044, 32'h0,        3'b010, 0, 0, 32'h5A5A_0F0F, 4'b1111, 32'h0,        32'h5A5A_0F0F);

`ifdef DMEM_TIMEOUT_EN
      // No grant ever: abort after 8 cycles with a bus error and rdata cleared.
      begin
         done_exp_t d;
         int k;
         d.rdata = 32'd0; d.stall = 9;
         done_q.push_back(d);
         err_q.push_back(1);
         mem_read_i = 1'b1; addr_i = 32'h0000_0050; funct3_i = 3'b010;
         k = 0;
         @(posedge clk); #1;
         while (stall_o && k < 40) begin
            @(posedge clk); #1;
            k++;
         end
         chk("timeout_release", {31'd0, stall_o}, 32'd0);
         @(posedge clk); #1;
         mem_read_i = 1'b0;
         @(posedge clk); #1;
      end
`endif

      repeat (3) @(posedge clk);
      #1;
      chk("bus_q_drained", 32'(bus_q.size()), 32'd0);
      chk("done_q_drained", 32'(done_q.size()), 32'd0);
      chk("mis_q_drained", 32'(mis_q.size()), 32'd0);
      chk("rst_q_drained", 32'(rst_q.size()), 32'd0);
      chk("err_q_drained", 32'(err_q.size()), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
